c432_irq_dispatch: RTL and testbench

// - Downstream stage of the C432 27-channel interrupt priority netlist.
// - Registers the netlist's 7 outputs (3 bus flags, 4-bit channel) and filters settling glitches.
// - Converts each stable, newly granted request into one FIFO entry, then hands it to the consumer over valid/ready.
// - Counts requests dropped when the FIFO is full.

---
 rtl/c432_irq_dispatch.sv | 103 ++++++++++
 tb/tb_c432_irq_dispatch.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/c432_irq_dispatch.sv
// c432_irq_dispatch: debounces C432 grant vectors and queues each new stable grant for a valid/ready consumer
module c432_irq_dispatch #(
   parameter int STABLE_CYCLES = 2,
   parameter int DEPTH         = 4,
   parameter int DROP_W        = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic              pa,
   input  logic              pb,
   input  logic              pc,
   input  logic [3:0]        chan,
   output logic              irq_valid,
   input  logic              irq_ready,
   output logic [1:0]        irq_bus,
   output logic [3:0]        irq_chan,
   output logic              fifo_full,
   output logic [DROP_W-1:0] drop_cnt,
   input  logic              drop_clr
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [3:0] STB = 4'(STABLE_CYCLES);
   localparam logic [AW:0] FULLV = (AW+1)'(DEPTH);
   typedef enum logic [1:0] {IDLE, SETTLE, LOCKED} state_t;
   state_t            r_state;
   logic [6:0]        r_samp;
   logic [3:0]        r_cnt;
   logic [5:0]        r_mem [DEPTH];
   logic [AW-1:0]     r_wr, r_rd;
   logic [AW:0]       r_occ;
   logic [5:0]        r_last;
   logic [DROP_W-1:0] r_drop;
   logic [6:0]        w_new;
   logic              w_chg, w_new_grant, w_grant, w_accept, w_full, w_valid, w_pop, w_push, w_drop;
   logic [1:0]        w_bus;
   assign w_new       = {pa, pb, pc, chan};
   assign w_chg       = w_new != r_samp;
   assign w_new_grant = |w_new[6:4];
   assign w_grant     = |r_samp[6:4];
   assign w_bus       = r_samp[6] ? 2'd0 : r_samp[5] ? 2'd1 : 2'd2;
   assign w_accept    = en && !w_chg && r_state == SETTLE && r_cnt == STB;
   assign w_full      = r_occ == FULLV;
   assign w_valid     = r_occ != '0;
   assign w_pop       = w_valid && irq_ready;
   assign w_push      = w_accept && (!w_full || w_pop);
   assign w_drop      = w_accept && !w_push;
   assign irq_valid   = w_valid;
   assign {irq_bus, irq_chan} = w_valid ? r_mem[r_rd] : r_last;
   assign fifo_full   = w_full;
   assign drop_cnt    = r_drop;
   // sample the netlist outputs and count how long the vector has held
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_samp <= '0;
         r_cnt  <= '0;
      end else begin
         r_samp <= w_new;
         r_cnt  <= w_chg ? 4'd1 : (r_cnt >= STB ? STB : r_cnt + 4'd1);
      end
   // grant tracking: settle on a new granted vector, lock once accepted until it changes
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n)
         r_state <= IDLE;
      else if (!en)
         r_state <= IDLE;
      else if (w_chg)
         r_state <= w_new_grant ? SETTLE : IDLE;
      else if (r_state == SETTLE && r_cnt == STB)
         r_state <= LOCKED;
      else if (r_state == IDLE && w_grant)
         r_state <= SETTLE;
   // request FIFO; the last popped entry is kept so the head outputs hold while empty
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
         r_wr   <= '0;
         r_rd   <= '0;
         r_occ  <= '0;
         r_last <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wr] <= {w_bus, r_samp[3:0]};
            r_wr        <= r_wr + 1'b1;
         end
         if (w_pop) begin
            r_rd   <= r_rd + 1'b1;
            r_last <= r_mem[r_rd];
         end
         if (w_push && !w_pop)
            r_occ <= r_occ + 1'b1;
         else if (w_pop && !w_push)
            r_occ <= r_occ - 1'b1;
      end
   // saturating drop counter; clear wins over a same-cycle drop
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n)
         r_drop <= '0;
      else if (drop_clr)
         r_drop <= '0;
      else if (w_drop && !(&r_drop))
         r_drop <= r_drop + 1'b1;
endmodule

// File: tb/tb_c432_irq_dispatch.sv
// tb_c432_irq_dispatch: directed stimulus with a queue scoreboard checked by an independent monitor
module tb_c432_irq_dispatch;
   logic       clk = 0, rst_n = 0, en = 1, pa = 0, pb = 0, pc = 0, irq_ready = 0, drop_clr = 0;
   logic [3:0] chan = 0;
   logic       irq_valid, fifo_full;
   logic [1:0] irq_bus;
   logic [3:0] irq_chan;
   logic [7:0] drop_cnt;
   int         n_chk = 0, n_fail = 0;
   logic [5:0] sb [$];
   logic [5:0] e;

   c432_irq_dispatch #(.STABLE_CYCLES(2), .DEPTH(4), .DROP_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .pa(pa), .pb(pb), .pc(pc), .chan(chan),
      .irq_valid(irq_valid), .irq_ready(irq_ready), .irq_bus(irq_bus), .irq_chan(irq_chan),
      .fifo_full(fifo_full), .drop_cnt(drop_cnt), .drop_clr(drop_clr)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic setv(input int b, input int c);
      pa   = (b == 0);
      pb   = (b == 1);
      pc   = (b == 2);
      chan = 4'(c);
   endtask

   task automatic setz();
      pa = 0; pb = 0; pc = 0; chan = 0;
   endtask

   // monitor: every handshake must match the oldest expected entry
   always @(negedge clk)
      if (rst_n && irq_valid === 1'b1 && irq_ready) begin
         if (sb.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_entry: got bus=%0d chan=%0d expected none", irq_bus, irq_chan);
         end else begin
            e = sb.pop_front();
            check("sb_entry", 32'({irq_bus, irq_chan}), 32'(e));
         end
      end

   initial begin
      tick(2);
      check("rst_valid", 32'(irq_valid), 0);
      check("rst_bus", 32'(irq_bus), 0);
      check("rst_chan", 32'(irq_chan), 0);
      check("rst_full", 32'(fifo_full), 0);
      check("rst_drop", 32'(drop_cnt), 0);
      rst_n = 1;
      tick(1);
      // basic latency and single entry while held
      irq_ready = 1;
      setv(1, 5);
      sb.push_back({2'd1, 4'd5});
      tick(2);
      check("basic_valid_e2", 32'(irq_valid), 0);
      tick(1);
      check("basic_valid_e3", 32'(irq_valid), 1);
      check("basic_bus", 32'(irq_bus), 1);
      check("basic_chan", 32'(irq_chan), 5);
      tick(1);
      check("basic_popped", 32'(irq_valid), 0);
      tick(5);
      check("basic_no_repeat", 32'(irq_valid), 0);
      setz();
      tick(3);
      // glitch filtering
      setv(1, 5); tick(1);
      setv(1, 6); tick(1);
      setv(1, 5); tick(1);
      check("glitch_no_push", 32'(irq_valid), 0);
      setv(1, 6);
      sb.push_back({2'd1, 4'd6});
      tick(2);
      check("glitch_settling", 32'(irq_valid), 0);
      tick(4);
      setz();
      tick(3);
      check("glitch_sb_empty", 32'(sb.size()), 0);
      // overflow
      irq_ready = 0;
      for (int i = 1; i <= 6; i++) begin
         setv(0, i);
         if (i <= 4) sb.push_back({2'd0, 4'(i)});
         tick(4);
      end
      check("ovf_full", 32'(fifo_full), 1);
      check("ovf_drop", 32'(drop_cnt), 2);
      check("ovf_head_bus", 32'(irq_bus), 0);
      check("ovf_head_chan", 32'(irq_chan), 1);
      // accept and pop on the same edge while full
      setv(2, 9);
      tick(2);
      irq_ready = 1;
      tick(1);
      irq_ready = 0;
      sb.push_back({2'd2, 4'd9});
      check("simul_full", 32'(fifo_full), 1);
      check("simul_drop", 32'(drop_cnt), 2);
      check("simul_head_chan", 32'(irq_chan), 2);
      irq_ready = 1;
      tick(6);
      check("drain_valid", 32'(irq_valid), 0);
      check("drain_hold_bus", 32'(irq_bus), 2);
      check("drain_hold_chan", 32'(irq_chan), 9);
      check("drain_full", 32'(fifo_full), 0);
      // enable low suppresses enqueue
      en = 0;
      setv(0, 3);
      tick(6);
      check("en_off_valid", 32'(irq_valid), 0);
      setz();
      tick(1);
      en = 1;
      tick(2);
      check("en_on_valid", 32'(irq_valid), 0);
      // clear beats a same-cycle drop
      irq_ready = 0;
      for (int i = 0; i < 4; i++) begin
         setv(1, 10 + i);
         sb.push_back({2'd1, 4'(10 + i)});
         tick(4);
      end
      check("clr_full", 32'(fifo_full), 1);
      check("clr_drop_before", 32'(drop_cnt), 2);
      setv(0, 14);
      tick(2);
      drop_clr = 1;
      tick(1);
      drop_clr = 0;
      check("clr_drop_after", 32'(drop_cnt), 0);
      check("clr_still_full", 32'(fifo_full), 1);
      irq_ready = 1;
      tick(6);
      check("clr_drain_valid", 32'(irq_valid), 0);
      // pointer wrap with continuous draining
      for (int i = 0; i < 20; i++) begin
         setv(i % 3, i % 16);
         sb.push_back({2'(i % 3), 4'(i % 16)});
         tick(4);
      end
      setz();
      tick(3);
      check("wrap_sb_empty", 32'(sb.size()), 0);
      check("wrap_valid", 32'(irq_valid), 0);
      // asynchronous reset with entries queued
      irq_ready = 0;
      for (int i = 0; i < 3; i++) begin
         setv(2, i + 1);
         tick(4);
      end
      check("pre_rst_valid", 32'(irq_valid), 1);
      check("pre_rst_bus", 32'(irq_bus), 2);
      #2 rst_n = 0;
      #1;
      check("arst_valid", 32'(irq_valid), 0);
      check("arst_bus", 32'(irq_bus), 0);
      check("arst_chan", 32'(irq_chan), 0);
      check("arst_full", 32'(fifo_full), 0);
      check("arst_drop", 32'(drop_cnt), 0);
      setz();
      tick(1);
      rst_n = 1;
      irq_ready = 1;
      tick(5);
      check("post_rst_valid", 32'(irq_valid), 0);
      check("final_sb_empty", 32'(sb.size()), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
